demux1x2_stage: RTL and testbench
=================================

# demux1x2_stage

Registered 1-to-2 demultiplexer with valid/ready handshakes: the steering counterpart of the datapath 2:1 mux. One 32-bit input stream is routed, per transfer, to output channel 0 or 1 according to a select bit, through an independent one-entry register slot per channel. It sits between the execute stage and its two consumers, for example the register-writeback path (channel 0) and the memory-store path (channel 1). A stalled consumer blocks only its own channel.

## Interface
Parameters:
- WIDTH, 32, data width of input and both outputs

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  WIDTH  payload to steer
- in_sel  input  1  destination: 0 → channel 0, 1 → channel 1
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  transfer accepted when in_valid && in_ready
- out0_data  output  WIDTH  channel 0 payload
- out0_valid  output  1  channel 0 slot full
- out0_ready  input  1  channel 0 consumer accepts
- out1_data  output  WIDTH  channel 1 payload
- out1_valid  output  1  channel 1 slot full
- out1_ready  input  1  channel 1 consumer accepts
- out0_count  output  16  channel 0 handshake count (only with DEMUX_STATS_EN)
- out1_count  output  16  channel 1 handshake count (only with DEMUX_STATS_EN)

## Operation
- Each channel slot has two states, EMPTY and FULL; outN_valid = (state == FULL).
- Reset: both slots EMPTY, outN_valid=0, outN_data=0, counters=0.
- in_ready = (slot[in_sel] EMPTY) || outN_ready for N = in_sel. The path from outN_ready and in_sel to in_ready is combinational and intended.
- Accept (in_valid && in_ready): slot[in_sel] loads in_data and enters FULL. The other slot is unaffected.
- Drain (outN_valid && outN_ready): slot N enters EMPTY unless a new accept targets N in the same cycle. In that case it reloads and stays FULL, keeping throughput at 1 transfer per cycle per channel.
- While outN_valid && !outN_ready, outN_data holds stable.
- The channels are independent. A full, stalled channel 1 does not block transfers with in_sel=0.
- Ordering is preserved within a channel. No ordering is guaranteed across channels.
- in_sel and in_data are sampled only on accept. Their values while in_valid=0 are ignored.
- An asynchronous rst asserted mid-transfer discards slot contents immediately. No handshake completes in that cycle.

## Timing
- Latency: accept at edge k makes the data visible on outN_data/outN_valid after edge k.
- Throughput: 1 transfer per cycle on sustained traffic, with any mix of channels, while consumers hold ready=1.
- No bubbles on a full slot when the consumer is ready in the same cycle.
- Outputs are registered. Only in_ready is combinational.

## Configuration
- DEMUX_STATS_EN defined: adds out0_count and out1_count as 16-bit counters.
  - Each counter increments by 1 on every output handshake of its channel.
  - Counters wrap from 0xFFFF to 0x0000.
  - Counters reset to 0.
- DEMUX_STATS_EN undefined: the count ports and counter logic are absent. Handshake behaviour is identical.

## Structure
- Shared package demux_pkg holds:
  - DATA_W = 32
  - CNT_W = 16
  - the slot_state_t enum {EMPTY, FULL}
- Sub-module demux_slot implements one channel's register slot plus its optional counter. It is instantiated twice. The top level contains only in_ready selection and load-enable steering.

## Test plan
- Reset: assert rst mid-transfer with out0_valid=1 → out0_valid=out1_valid=0, data=0, counts=0 immediately, without waiting for a clock edge.
- Single steer: in_data=0xDEADBEEF, in_sel=1, valid for one cycle, consumers ready → out1_valid=1 with 0xDEADBEEF one cycle later, out0_valid stays 0.
- Back-pressure isolation: out0_ready=0, two beats to channel 0.
  - Required: first beat held stable, in_ready=0 on the second beat.
  - Then a beat 0x1234 to channel 1 → accepted and appears on out1.
- Full-and-drain same cycle: slot 0 holds 0xA, out0_ready=1, new beat 0xB to channel 0 → accepted, out0_valid stays 1, out0_data=0xB next cycle.
- Streaming: 100 beats alternating in_sel, consumers always ready → in_ready constantly 1, per-channel order preserved, 50 handshakes per channel.
- Counter wrap (DEMUX_STATS_EN): 65537 handshakes on channel 1 → out1_count=1, out0_count=0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and widths for the 1-to-2 steering demultiplexer.
// Used by demux_slot, demux1x2_stage and their interface.
package demux_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/demux1x2_stage_if.sv
// Handshake bundle for demux1x2_stage: one input stream, two output channels.
// Optional per-channel handshake counters appear when DEMUX_STATS_EN is defined.
interface demux1x2_stage_if #(
  parameter int WIDTH = demux_pkg::DATA_W
);

  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

`ifdef DEMUX_STATS_EN
  logic [demux_pkg::CNT_W-1:0] out0_count;
  logic [demux_pkg::CNT_W-1:0] out1_count;
`endif

  // Producer/consumer side: drives the input stream and both consumer readies.
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX_STATS_EN
    , input out0_count, out1_count
`endif
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
`ifdef DEMUX_STATS_EN
    , output out0_count, out1_count
`endif
  );

endinterface

// File: rtl/demux_slot.sv
// One-entry registered output slot (EMPTY/FULL) for a single demux channel,
// with an optional wrapping handshake counter when DEMUX_STATS_EN is defined.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
`ifdef DEMUX_STATS_EN
  , output logic [CNT_W-1:0] count
`endif
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  logic             drain;
  logic [WIDTH-1:0] data_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY:   if (load) state_d = FULL;
      FULL:    if (drain && !load) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    valid = (state_q == FULL);
    drain = valid && ready;
    data  = data_q;
  end

  // NOTE: the payload register is reset because a cleared output is observable after rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_q <= '0;
    else if (load) data_q <= load_data;
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] count_q;

  // Natural modulo-2^CNT_W wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        count_q <= '0;
    else if (drain) count_q <= count_q + CNT_W'(1);
  end

  assign count = count_q;
`endif

endmodule

// File: rtl/demux1x2_stage.sv
// Registered 1-to-2 valid/ready demultiplexer: steers each accepted beat into
// channel slot in_sel. Optional counters enabled by defining DEMUX_STATS_EN.
module demux1x2_stage
  import demux_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input logic              clk,
  input logic              rst,
  demux1x2_stage_if.slave  bus
);

  logic accept;
  logic load0;
  logic load1;

  // Only the addressed channel gates acceptance; a stalled sibling never blocks it.
  always_comb begin
    bus.in_ready = bus.in_sel ? (!bus.out1_valid || bus.out1_ready)
                              : (!bus.out0_valid || bus.out0_ready);
    accept       = bus.in_valid && bus.in_ready;
    load0        = accept && !bus.in_sel;
    load1        = accept &&  bus.in_sel;
  end

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (bus.in_data),
    .ready     (bus.out0_ready),
    .valid     (bus.out0_valid),
    .data      (bus.out0_data)
`ifdef DEMUX_STATS_EN
    , .count   (bus.out0_count)
`endif
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (bus.in_data),
    .ready     (bus.out1_ready),
    .valid     (bus.out1_valid),
    .data      (bus.out1_data)
`ifdef DEMUX_STATS_EN
    , .count   (bus.out1_count)
`endif
  );

endmodule

// File: tb/tb_demux1x2_stage.sv
// Self-checking bench for demux1x2_stage: directed scenarios plus a per-channel
// scoreboard fed on input handshakes and drained on output handshakes.
module tb_demux1x2_stage;
  import demux_pkg::*;

  logic clk;
  logic rst;

  demux1x2_stage_if #(.WIDTH(DATA_W)) bus ();

  demux1x2_stage #(.WIDTH(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int hs0;
  int hs1;
  logic [DATA_W-1:0] exp0[$];
  logic [DATA_W-1:0] exp1[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_sel   = 1'b0;
    bus.in_data  = '0;
  endtask

  // Samples mid-cycle: pops/compares on output handshakes, pushes on input ones.
  task automatic monitor();
    logic [DATA_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out0_valid && bus.out0_ready) begin
          hs0++;
          checks++;
          if (exp0.size() == 0) begin
            failures++;
            $display("FAIL sb_ch0_unexpected: got %h, required no beat", bus.out0_data);
          end else begin
            e = exp0.pop_front();
            if (bus.out0_data !== e) begin
              failures++;
              $display("FAIL sb_ch0_data: got %h, required %h", bus.out0_data, e);
            end
          end
        end
        if (bus.out1_valid && bus.out1_ready) begin
          hs1++;
          checks++;
          if (exp1.size() == 0) begin
            failures++;
            $display("FAIL sb_ch1_unexpected: got %h, required no beat", bus.out1_data);
          end else begin
            e = exp1.pop_front();
            if (bus.out1_data !== e) begin
              failures++;
              $display("FAIL sb_ch1_data: got %h, required %h", bus.out1_data, e);
            end
          end
        end
        if (bus.in_valid && bus.in_ready) begin
          if (bus.in_sel) exp1.push_back(bus.in_data);
          else            exp0.push_back(bus.in_data);
        end
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    checks++;
    if (bus.out0_valid !== 1'b0 || bus.out1_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_valid: got v0=%b v1=%b, required 0 0", tag, bus.out0_valid, bus.out1_valid);
    end
    checks++;
    if (bus.out0_data !== '0 || bus.out1_data !== '0) begin
      failures++;
      $display("FAIL %s_data: got d0=%h d1=%h, required 0 0", tag, bus.out0_data, bus.out1_data);
    end
`ifdef DEMUX_STATS_EN
    checks++;
    if (bus.out0_count !== '0 || bus.out1_count !== '0) begin
      failures++;
      $display("FAIL %s_count: got c0=%0d c1=%0d, required 0 0", tag, bus.out0_count, bus.out1_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (2) tick();
    check_cleared("reset_init");
    rst = 1'b0;
    tick();

    // Park a beat in slot 0, then hit rst between clock edges.
    bus.out0_ready = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b0;
    bus.in_data    = 32'hCAFE_F00D;
    tick();
    idle_inputs();
    checks++;
    if (bus.out0_valid !== 1'b1) begin
      failures++;
      $display("FAIL reset_preload: got out0_valid=%b, required 1", bus.out0_valid);
    end
    #2 rst = 1'b1;
    #1 check_cleared("reset_async");
    tick();
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    bus.out0_ready = 1'b1;
    tick();
  endtask

  task automatic test_single_steer();
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b1;
    bus.in_data    = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL steer_in_ready: got %b, required 1", bus.in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL steer_out1: got v=%b d=%h, required 1 deadbeef", bus.out1_valid, bus.out1_data);
    end
    checks++;
    if (bus.out0_valid !== 1'b0) begin
      failures++;
      $display("FAIL steer_out0_idle: got %b, required 0", bus.out0_valid);
    end
    repeat (2) tick();
  endtask

  task automatic test_backpressure();
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b0;
    bus.in_data    = 32'h1111_0000;
    tick();
    bus.in_data = 32'h2222_0000;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_in_ready c%0d: got %b, required 0", c, bus.in_ready);
      end
      checks++;
      if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h1111_0000) begin
        failures++;
        $display("FAIL bp_hold c%0d: got v=%b d=%h, required 1 11110000", c, bus.out0_valid, bus.out0_data);
      end
      tick();
    end
    // Channel 1 must still flow while channel 0 stalls.
    bus.in_sel  = 1'b1;
    bus.in_data = 32'h0000_1234;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ch1_ready: got %b, required 1", bus.in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.out1_valid !== 1'b1 || bus.out1_data !== 32'h0000_1234) begin
      failures++;
      $display("FAIL bp_ch1_out: got v=%b d=%h, required 1 00001234", bus.out1_valid, bus.out1_data);
    end
    checks++;
    if (bus.out0_data !== 32'h1111_0000) begin
      failures++;
      $display("FAIL bp_ch0_still: got %h, required 11110000", bus.out0_data);
    end
    bus.out0_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_full_drain();
    bus.out0_ready = 1'b0;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b0;
    bus.in_data    = 32'h0000_000A;
    tick();
    bus.out0_ready = 1'b1;
    bus.in_data    = 32'h0000_000B;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fd_in_ready: got %b, required 1", bus.in_ready);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.out0_valid !== 1'b1 || bus.out0_data !== 32'h0000_000B) begin
      failures++;
      $display("FAIL fd_reload: got v=%b d=%h, required 1 0000000b", bus.out0_valid, bus.out0_data);
    end
    repeat (2) tick();
  endtask

  task automatic test_streaming();
    int h0, h1, not_ready;
    h0 = hs0;
    h1 = hs1;
    not_ready = 0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = (i % 2 == 1);
      bus.in_data  = 32'h5000_0000 + DATA_W'(i);
      #1;
      if (bus.in_ready !== 1'b1) not_ready++;
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    checks++;
    if (not_ready != 0) begin
      failures++;
      $display("FAIL stream_in_ready: got %0d stalled beats, required 0", not_ready);
    end
    checks++;
    if (hs0 - h0 != 50 || hs1 - h1 != 50) begin
      failures++;
      $display("FAIL stream_handshakes: got ch0=%0d ch1=%0d, required 50 50", hs0 - h0, hs1 - h1);
    end
  endtask

`ifdef DEMUX_STATS_EN
  task automatic test_counter_wrap();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp0.delete();
    exp1.delete();
    bus.out1_ready = 1'b1;
    bus.in_valid   = 1'b1;
    bus.in_sel     = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      bus.in_data = DATA_W'(i);
      tick();
    end
    idle_inputs();
    repeat (2) tick();
    checks++;
    if (bus.out1_count !== 16'd1 || bus.out0_count !== 16'd0) begin
      failures++;
      $display("FAIL count_wrap: got c0=%0d c1=%0d, required 0 1", bus.out0_count, bus.out1_count);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    hs0      = 0;
    hs1      = 0;
    rst      = 1'b1;
    idle_inputs();
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    fork
      monitor();
    join_none

    test_reset();
    test_single_steer();
    test_backpressure();
    test_full_drain();
    test_streaming();
`ifdef DEMUX_STATS_EN
    test_counter_wrap();
`endif

    checks++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      failures++;
      $display("FAIL sb_drained: got %0d/%0d pending, required 0/0", exp0.size(), exp1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
